iic_slave_regs: RTL and testbench

IIC_SLAVE_REGS -- requirements
Module: iic_slave_regs

---
 rtl/iic_pkg.sv | 27 ++
 rtl/iic_slave_regs_if.sv | 28 ++
 rtl/iic_line_sync.sv | 54 +++++
 rtl/iic_slave_regs.sv | 184 ++++++++++++++++++
 tb/tb_iic_slave_regs.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/iic_pkg.sv
// Definitions shared by the I2C master and slave blocks.
// Contents: byte/counter/address widths, ACK/NACK bus levels and the slave
// register-interface FSM state encoding.
package iic_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned DEV_ADDR_W = 7;

    // SDA level seen during the acknowledge bit
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } slave_state_t;

endpackage

// File: rtl/iic_slave_regs_if.sv
// Bus bundle between the I2C slave register block and its surroundings.
// Signals: SCL / SDA_in (pad inputs), SDA_oe (open-drain pull-down enable),
// wr_en / wr_addr / wr_data (register write strobe), rd_addr / rd_data
// (register read port), busy (addressed transaction in progress).
interface iic_slave_regs_if;
    import iic_pkg::*;

    logic              SCL;
    logic              SDA_in;
    logic              SDA_oe;
    logic              wr_en;
    logic [BYTE_W-1:0] wr_addr;
    logic [BYTE_W-1:0] wr_data;
    logic [BYTE_W-1:0] rd_addr;
    logic [BYTE_W-1:0] rd_data;
    logic              busy;

    modport slave (
        input  SCL, SDA_in, rd_data,
        output SDA_oe, wr_en, wr_addr, wr_data, rd_addr, busy
    );

    modport master (
        output SCL, SDA_in, rd_data,
        input  SDA_oe, wr_en, wr_addr, wr_data, rd_addr, busy
    );

endinterface

// File: rtl/iic_line_sync.sv
// Synchronizes SCL/SDA into the clk domain and flags bus events.
// Ports: clk, rst (async active-high), scl_in/sda_in (raw pad levels),
// sda (synchronized SDA, aligned with the event pulses), scl_rise, scl_fall,
// start_det, stop_det (one-cycle registered pulses).
module iic_line_sync #(
    parameter int unsigned FILTER_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [FILTER_LEN-1:0] scl_sync;
    logic [FILTER_LEN-1:0] sda_sync;
    logic                  scl_hist;
    logic                  sda_hist;
    logic                  scl_s;
    logic                  sda_s;

    assign scl_s = scl_sync[FILTER_LEN-1];
    assign sda_s = sda_sync[FILTER_LEN-1];

    // Sync chains idle high like the bus; events compare last stage vs history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_hist  <= 1'b1;
            sda_hist  <= 1'b1;
            sda       <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= (scl_sync << 1) | FILTER_LEN'(scl_in);
            sda_sync  <= (sda_sync << 1) | FILTER_LEN'(sda_in);
            scl_hist  <= scl_s;
            sda_hist  <= sda_s;
            sda       <= sda_s;
            scl_rise  <= scl_s & ~scl_hist;
            scl_fall  <= ~scl_s & scl_hist;
            start_det <= scl_s & scl_hist & sda_hist & ~sda_s;
            stop_det  <= scl_s & scl_hist & ~sda_hist & sda_s;
        end
    end

endmodule

// File: rtl/iic_slave_regs.sv
// I2C slave exposing an 8-bit register pointer and byte-wide register port.
// Ports: clk, rst (async active-high), bus (iic_slave_regs_if.slave):
// SCL/SDA_in in, SDA_oe out, wr_en/wr_addr/wr_data write strobe,
// rd_addr/rd_data read port, busy.
// Protocol: [addr/W][reg][data...] writes from reg upward; a repeated START
// followed by [addr/R] reads from the current pointer upward.
module iic_slave_regs
    import iic_pkg::*;
#(
    parameter logic [DEV_ADDR_W-1:0] SLAVE_ADDR = 7'h76,
    parameter int unsigned           FILTER_LEN = 2
) (
    input logic               clk,
    input logic               rst,
    iic_slave_regs_if.slave   bus
);

    slave_state_t         state;
    logic [BYTE_W-1:0]    shift;
    logic [BYTE_W-1:0]    ptr;
    logic [BYTE_W-1:0]    wr_addr_q;
    logic [BYTE_W-1:0]    wr_data_q;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 sda_oe;
    logic                 wr_en;
    logic                 busy;
    logic                 rw;

    logic                 sda;
    logic                 scl_rise;
    logic                 scl_fall;
    logic                 start_det;
    logic                 stop_det;
    logic [BYTE_W-1:0]    rx_byte;
    logic                 last_bit;

    iic_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (bus.SCL),
        .sda_in    (bus.SDA_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Byte as it will look once the bit on the bus this cycle is shifted in
    assign rx_byte  = {shift[BYTE_W-2:0], sda};
    assign last_bit = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));

    // Protocol FSM; START/STOP win over any bit activity in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift     <= '0;
            ptr       <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            bit_cnt   <= '0;
            sda_oe    <= 1'b0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (last_bit) begin
                            if (rx_byte[BYTE_W-1:1] == SLAVE_ADDR) begin
                                state <= ST_ADDR_ACK;
                                rw    <= sda;
                                busy  <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_REG: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (last_bit) begin
                            ptr   <= rx_byte;
                            state <= ST_REG_ACK;
                        end
                    end
                    ST_WDATA: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (last_bit) begin
                            wr_en     <= 1'b1;
                            wr_addr_q <= ptr;
                            wr_data_q <= rx_byte;
                            state     <= ST_WDATA_ACK;
                        end
                    end
                    // ACK states: first fall pulls SDA low, second fall releases and exits
                    ST_ADDR_ACK: if (scl_fall) begin
                        bit_cnt <= '0;
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rw) begin
                            state  <= ST_RDATA;
                            shift  <= bus.rd_data;
                            sda_oe <= ~bus.rd_data[BYTE_W-1];
                        end else begin
                            state  <= ST_REG;
                            sda_oe <= 1'b0;
                        end
                    end
                    ST_REG_ACK: if (scl_fall) begin
                        bit_cnt <= '0;
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            state  <= ST_WDATA;
                            sda_oe <= 1'b0;
                        end
                    end
                    ST_WDATA_ACK: if (scl_fall) begin
                        bit_cnt <= '0;
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            state  <= ST_WDATA;
                            sda_oe <= 1'b0;
                            ptr    <= ptr + BYTE_W'(1);
                        end
                    end
                    // Shift on rise keeps shift[7] holding the next bit to drive
                    ST_RDATA: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == '0) begin
                                state  <= ST_RDATA_ACK;
                                sda_oe <= 1'b0;
                            end else begin
                                sda_oe <= ~shift[BYTE_W-1];
                            end
                        end
                    end
                    // Pointer moves on the ACK rise so rd_data has settled by the fall
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            case (sda)
                                ACK:     ptr   <= ptr + BYTE_W'(1);
                                NACK:    state <= ST_IGNORE;
                                default: ;
                            endcase
                        end else if (scl_fall) begin
                            state   <= ST_RDATA;
                            bit_cnt <= '0;
                            shift   <= bus.rd_data;
                            sda_oe  <= ~bus.rd_data[BYTE_W-1];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.SDA_oe  = sda_oe;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_addr = ptr;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bench for iic_slave_regs: a behavioural I2C master drives SCL/SDA, the
// bus is modelled as wired-AND, and a register array answers rd_data.
// Expected writes/reads come from pointer arithmetic over the transactions.
module tb_iic_slave_regs;

    localparam int unsigned Q   = 10;      // clk cycles per quarter SCL period
    localparam logic [6:0]  DEV = 7'h76;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m;
    logic        sda_m;
    logic        last_sample;
    logic        oe_seen;
    logic        busy_seen;
    logic [7:0]  mem [256];
    logic [15:0] wr_q [$];
    int          checks = 0;
    int          errors = 0;

    iic_slave_regs_if bus_if ();

    assign bus_if.SCL     = scl_m;
    assign bus_if.SDA_in  = sda_m & ~bus_if.SDA_oe;
    assign bus_if.rd_data = mem[bus_if.rd_addr];

    iic_slave_regs #(.SLAVE_ADDR(DEV), .FILTER_LEN(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.wr_en)  wr_q.push_back({bus_if.wr_addr, bus_if.wr_data});
        if (bus_if.SDA_oe) oe_seen = 1'b1;
        if (bus_if.busy)   busy_seen = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period; SDA only moves a quarter period after SCL fell
    task automatic clock_bit(input logic b);
        wait_clk(Q); sda_m = b;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); last_sample = bus_if.SDA_in;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q);
    endtask

    // Leaves the slave's ACK level in last_sample
    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) clock_bit(b[i]);
        clock_bit(1'b1);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1);
            b[i] = last_sample;
        end
        clock_bit(mack);
    endtask

    task automatic write_txn(input logic [7:0] ra, input logic [7:0] d[$], output int bad);
        bad = 0;
        i2c_start();
        send_byte({DEV, 1'b0}); if (last_sample !== 1'b0) bad++;
        send_byte(ra);          if (last_sample !== 1'b0) bad++;
        foreach (d[i]) begin
            send_byte(d[i]);    if (last_sample !== 1'b0) bad++;
        end
        i2c_stop();
        wait_clk(4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(5);
        checks++; if (bus_if.SDA_oe !== 1'b0)  begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", bus_if.SDA_oe); end
        checks++; if (bus_if.wr_en !== 1'b0)   begin errors++; $display("FAIL reset_wr_en: got %b expected 0", bus_if.wr_en); end
        checks++; if (bus_if.wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", bus_if.wr_addr); end
        checks++; if (bus_if.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", bus_if.wr_data); end
        checks++; if (bus_if.rd_addr !== 8'h00) begin errors++; $display("FAIL reset_rd_addr: got %h expected 00", bus_if.rd_addr); end
        checks++; if (bus_if.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        rst = 1'b0;
        wait_clk(4 * Q);
        checks++; if (bus_if.SDA_oe !== 1'b0)  begin errors++; $display("FAIL idle_sda_oe: got %b expected 0", bus_if.SDA_oe); end
    endtask

    task automatic test_single_write();
        logic a0, a1, a2, busy_mid;
        wr_q.delete();
        i2c_start();
        send_byte({DEV, 1'b0}); a0 = last_sample; busy_mid = bus_if.busy;
        send_byte(8'h21);       a1 = last_sample;
        send_byte(8'h09);       a2 = last_sample;
        i2c_stop();
        wait_clk(4);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL single_acks: got %b expected 000", {a0, a1, a2}); end
        checks++; if (busy_mid !== 1'b1)       begin errors++; $display("FAIL single_busy_mid: got %b expected 1", busy_mid); end
        checks++; if (bus_if.busy !== 1'b0)    begin errors++; $display("FAIL single_busy_end: got %b expected 0", bus_if.busy); end
        checks++; if (wr_q.size() != 1)        begin errors++; $display("FAIL single_wr_count: got %0d expected 1", wr_q.size()); end
        else begin
            checks++; if (wr_q[0] !== 16'h2109) begin errors++; $display("FAIL single_wr: got %h expected 2109", wr_q[0]); end
        end
        checks++; if (bus_if.rd_addr !== 8'h22) begin errors++; $display("FAIL single_ptr: got %h expected 22", bus_if.rd_addr); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0]  ra;
        logic [7:0]  d[$];
        logic [15:0] exp;
        int          bad;
        for (int t = 0; t < 4; t++) begin
            d.delete();
            if (t == 0) begin
                ra = 8'hFF; d.push_back(8'hA1); d.push_back(8'hA2);
            end else begin
                ra = 8'($urandom);
                if (t == 1) ra = 8'hFE;
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) d.push_back(8'($urandom));
            end
            wr_q.delete();
            write_txn(ra, d, bad);
            checks++; if (bad != 0) begin errors++; $display("FAIL burst_acks[%0d]: got %0d missing expected 0", t, bad); end
            checks++;
            if (wr_q.size() != d.size()) begin
                errors++; $display("FAIL burst_count[%0d]: got %0d expected %0d", t, wr_q.size(), d.size());
            end else begin
                for (int i = 0; i < d.size(); i++) begin
                    exp = {8'(ra + 8'(i)), d[i]};
                    checks++; if (wr_q[i] !== exp) begin errors++; $display("FAIL burst_wr[%0d.%0d]: got %h expected %h", t, i, wr_q[i], exp); end
                end
            end
            exp[7:0] = 8'(ra + 8'(d.size()));
            checks++; if (bus_if.rd_addr !== exp[7:0]) begin errors++; $display("FAIL burst_ptr[%0d]: got %h expected %h", t, bus_if.rd_addr, exp[7:0]); end
        end
    endtask

    task automatic test_wrong_addr();
        logic [6:0] a;
        logic       ack;
        for (int t = 0; t < 3; t++) begin
            if (t == 0) a = 7'h4C;
            else do a = 7'($urandom); while (a == DEV);
            oe_seen = 1'b0; busy_seen = 1'b0; wr_q.delete();
            i2c_start();
            send_byte({a, 1'b0}); ack = last_sample;
            send_byte(8'h21);
            send_byte(8'h09);
            i2c_stop();
            wait_clk(4);
            checks++; if (ack !== 1'b1)       begin errors++; $display("FAIL wrong_ack[%h]: got %b expected 1", a, ack); end
            checks++; if (oe_seen !== 1'b0)   begin errors++; $display("FAIL wrong_oe[%h]: got %b expected 0", a, oe_seen); end
            checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL wrong_busy[%h]: got %b expected 0", a, busy_seen); end
            checks++; if (wr_q.size() != 0)   begin errors++; $display("FAIL wrong_wr[%h]: got %0d expected 0", a, wr_q.size()); end
        end
    endtask

    task automatic test_read_single();
        logic [7:0] b;
        logic       ack;
        wr_q.delete();
        i2c_start();
        send_byte({DEV, 1'b0});
        send_byte(8'h10);
        i2c_start();
        send_byte({DEV, 1'b1}); ack = last_sample;
        recv_byte(1'b1, b);
        checks++; if (ack !== 1'b0)          begin errors++; $display("FAIL read1_ack: got %b expected 0", ack); end
        checks++; if (b !== 8'h5A)           begin errors++; $display("FAIL read1_byte: got %h expected 5a", b); end
        checks++; if (bus_if.SDA_oe !== 1'b0) begin errors++; $display("FAIL read1_release: got %b expected 0", bus_if.SDA_oe); end
        checks++; if (bus_if.busy !== 1'b1)  begin errors++; $display("FAIL read1_busy: got %b expected 1", bus_if.busy); end
        i2c_stop();
        wait_clk(4);
        checks++; if (bus_if.busy !== 1'b0)  begin errors++; $display("FAIL read1_busy_end: got %b expected 0", bus_if.busy); end
        checks++; if (wr_q.size() != 0)      begin errors++; $display("FAIL read1_no_wr: got %0d expected 0", wr_q.size()); end
    endtask

    task automatic test_multi_read();
        logic [7:0] p, p1, b0, b1;
        for (int t = 0; t < 3; t++) begin
            p  = (t == 0) ? 8'h10 : (t == 1) ? 8'hFF : 8'($urandom);
            p1 = 8'(p + 8'd1);
            i2c_start();
            send_byte({DEV, 1'b0});
            send_byte(p);
            checks++; if (bus_if.rd_addr !== p) begin errors++; $display("FAIL mread_ptr0[%0d]: got %h expected %h", t, bus_if.rd_addr, p); end
            i2c_start();
            send_byte({DEV, 1'b1});
            recv_byte(1'b0, b0);
            checks++; if (b0 !== mem[p])          begin errors++; $display("FAIL mread_b0[%0d]: got %h expected %h", t, b0, mem[p]); end
            checks++; if (bus_if.rd_addr !== p1)  begin errors++; $display("FAIL mread_ptr1[%0d]: got %h expected %h", t, bus_if.rd_addr, p1); end
            recv_byte(1'b1, b1);
            checks++; if (b1 !== mem[p1])         begin errors++; $display("FAIL mread_b1[%0d]: got %h expected %h", t, b1, mem[p1]); end
            checks++; if (bus_if.rd_addr !== p1)  begin errors++; $display("FAIL mread_ptr2[%0d]: got %h expected %h", t, bus_if.rd_addr, p1); end
            i2c_stop();
            wait_clk(4);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] data;
        logic [7:0] d[$];
        int         bad;
        data = 8'hC5;
        wr_q.delete();
        i2c_start();
        send_byte({DEV, 1'b0});
        send_byte(8'h33);
        for (int i = 7; i >= 4; i--) clock_bit(data[i]);
        wait_clk(Q); sda_m = data[3];
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q / 2);
        rst = 1'b1;
        wait_clk(2);
        checks++; if (bus_if.SDA_oe !== 1'b0)   begin errors++; $display("FAIL mid_sda_oe: got %b expected 0", bus_if.SDA_oe); end
        checks++; if (bus_if.wr_en !== 1'b0)    begin errors++; $display("FAIL mid_wr_en: got %b expected 0", bus_if.wr_en); end
        checks++; if (bus_if.wr_addr !== 8'h00) begin errors++; $display("FAIL mid_wr_addr: got %h expected 00", bus_if.wr_addr); end
        checks++; if (bus_if.wr_data !== 8'h00) begin errors++; $display("FAIL mid_wr_data: got %h expected 00", bus_if.wr_data); end
        checks++; if (bus_if.rd_addr !== 8'h00) begin errors++; $display("FAIL mid_rd_addr: got %h expected 00", bus_if.rd_addr); end
        checks++; if (bus_if.busy !== 1'b0)     begin errors++; $display("FAIL mid_busy: got %b expected 0", bus_if.busy); end
        scl_m = 1'b0;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); rst = 1'b0;
        wait_clk(4 * Q);
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL mid_no_wr: got %0d expected 0", wr_q.size()); end
        d.push_back(8'h3C);
        write_txn(8'h5A, d, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_after_acks: got %0d missing expected 0", bad); end
        checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL mid_after_count: got %0d expected 1", wr_q.size()); end
        else begin
            checks++; if (wr_q[0] !== 16'h5A3C) begin errors++; $display("FAIL mid_after_wr: got %h expected 5a3c", wr_q[0]); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h5A;
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_wrong_addr();
        test_read_single();
        test_multi_read();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
